blit_outer_seq: RTL and testbench

- Outer-loop sequencer for the blitter.
- On a command start it repeatedly invokes the parameter-read state machine (RDPAR/PARDN handshake), then the inner-loop engine (INSTRT/INDONE handshake), once per outer iteration, until the outer count is exhausted or the command is stopped.
- Sits between the command register / CPU interface and the parameter-read and inner-loop state machines.
- Provides BUSY and DONE to the bus interface.

---
 rtl/blit_outer_seq.sv | 110 +++++++++++
 tb/tb_blit_outer_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_outer_seq.sv
// Outer-loop sequencer for the blitter: drives parameter reads and inner-loop runs per outer iteration.
// Optional single-step mode (HOLD state, STEP/PAUSED ports) is enabled by defining BLIT_STEP_EN.
module blit_outer_seq #(
  parameter int unsigned CNTW = 8
) (
  input  logic            CCLK,
  input  logic            SRESET,
  input  logic            START,
  input  logic [CNTW-1:0] OUTLD,
  input  logic            PARRDEN,
  input  logic            PARDN,
  input  logic            INDONE,
  input  logic            STOP,
`ifdef BLIT_STEP_EN
  input  logic            STEP,
  output logic            PAUSED,
`endif
  output logic            RDPAR,
  output logic            INSTRT,
  output logic            BUSY,
  output logic            DONE,
  output logic            STOPPED,
  output logic [CNTW-1:0] OUTCNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PARAM = 3'd1;
  localparam logic [2:0] S_INNER = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
`ifdef BLIT_STEP_EN
  localparam logic [2:0] S_HOLD  = 3'd4;
`endif

  logic [2:0]      state, state_d, cont_state;
  logic [CNTW-1:0] outcnt;
  logic            par_rd_q;
  logic            stopped_q;
  logic            instrt_q;
  logic            done_q;
  logic            last_iter;
  logic            accept;

  assign last_iter  = (outcnt == CNTW'(1));
  assign cont_state = par_rd_q ? S_PARAM : S_INNER;
  assign accept     = (state == S_IDLE) && START && !STOP;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = S_PARAM;
      S_PARAM: begin
        if (STOP)       state_d = S_IDLE;
        else if (PARDN) state_d = S_INNER;
      end
      S_INNER: begin
        if (STOP)        state_d = S_IDLE;
        else if (INDONE) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (STOP || last_iter) state_d = S_IDLE;
`ifdef BLIT_STEP_EN
        else                   state_d = S_HOLD;
`else
        else                   state_d = cont_state;
`endif
      end
`ifdef BLIT_STEP_EN
      S_HOLD: begin
        if (STOP)      state_d = S_IDLE;
        else if (STEP) state_d = cont_state;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (SRESET) begin
      state     <= S_IDLE;
      outcnt    <= '0;
      par_rd_q  <= 1'b0;
      stopped_q <= 1'b0;
      instrt_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_d;
      // INSTRT marks only the entry into INNER, never a stay in it
      instrt_q <= (state_d == S_INNER) && (state != S_INNER);
      done_q   <= (state == S_NEXT) && last_iter && !STOP;
      if (accept) begin
        outcnt    <= OUTLD;
        par_rd_q  <= PARRDEN;
        stopped_q <= 1'b0;
      end
      if ((state != S_IDLE) && STOP) stopped_q <= 1'b1;
      if ((state == S_NEXT) && !STOP) outcnt <= outcnt - CNTW'(1);
    end
  end

  assign RDPAR   = (state == S_PARAM);
  assign BUSY    = (state != S_IDLE);
  assign INSTRT  = instrt_q;
  assign DONE    = done_q;
  assign STOPPED = stopped_q;
  assign OUTCNT  = outcnt;
`ifdef BLIT_STEP_EN
  assign PAUSED  = (state == S_HOLD);
`endif

endmodule

// File: tb/tb_blit_outer_seq.sv
// Scoreboard bench for blit_outer_seq: expected RDPAR-rise/INSTRT/DONE events with OUTCNT are queued
// by the stimulus and popped by an independent monitor.
module tb_blit_outer_seq;

  logic       CCLK = 1'b0;
  logic       SRESET, START, PARRDEN, PARDN, INDONE, STOP;
  logic [7:0] OUTLD;
  logic       RDPAR, INSTRT, BUSY, DONE, STOPPED;
  logic [7:0] OUTCNT;
`ifdef BLIT_STEP_EN
  logic       STEP, PAUSED;
`endif

  typedef struct {
    byte        k;
    logic [7:0] c;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  stop_iter = 0;
  int  auto_step = 1;
  int  step_tok = 0;

  blit_outer_seq #(.CNTW(8)) dut (
    .CCLK(CCLK), .SRESET(SRESET), .START(START), .OUTLD(OUTLD), .PARRDEN(PARRDEN),
    .PARDN(PARDN), .INDONE(INDONE), .STOP(STOP),
`ifdef BLIT_STEP_EN
    .STEP(STEP), .PAUSED(PAUSED),
`endif
    .RDPAR(RDPAR), .INSTRT(INSTRT), .BUSY(BUSY), .DONE(DONE), .STOPPED(STOPPED), .OUTCNT(OUTCNT)
  );

  always #5 CCLK = ~CCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input byte k, input logic [7:0] c);
    ev_t e;
    e.k = k;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic see(input byte k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%c/%0d required=none", k, OUTCNT);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.c != OUTCNT) begin
        errors++;
        $display("FAIL event actual=%c/%0d required=%c/%0d", k, OUTCNT, e.k, e.c);
      end
    end
  endtask

  // Monitor: RDPAR rising edge, INSTRT pulse and DONE pulse are the observable events.
  initial begin
    logic rdpar_m;
    rdpar_m = 1'b0;
    forever begin
      @(negedge CCLK);
      if (!SRESET) begin
        if (RDPAR && !rdpar_m) see("R");
        if (INSTRT) see("I");
        if (DONE) see("D");
      end
      rdpar_m = RDPAR;
    end
  end

  // Responder for the parameter and inner-loop machines: PARDN 2 cycles after RDPAR rises,
  // INDONE 4 cycles after INSTRT; optionally STOP alongside a chosen INDONE, and STEP in HOLD.
  initial begin
    int   par_cnt, in_cnt, inst_seen, step_done;
    logic rdpar_q;
    par_cnt = 0; in_cnt = 0; inst_seen = 0; step_done = 0; rdpar_q = 1'b0;
    PARDN = 1'b0; INDONE = 1'b0; STOP = 1'b0;
`ifdef BLIT_STEP_EN
    STEP = 1'b0;
`endif
    forever begin
      @(negedge CCLK);
      PARDN = 1'b0; INDONE = 1'b0; STOP = 1'b0;
`ifdef BLIT_STEP_EN
      STEP = 1'b0;
`endif
      if (SRESET) begin
        par_cnt = 0; in_cnt = 0;
      end else begin
        if (!BUSY) inst_seen = 0;
        if (RDPAR && !rdpar_q) par_cnt = 1;
        else if (par_cnt != 0) par_cnt++;
        if (par_cnt == 2) begin PARDN = 1'b1; par_cnt = 0; end
        if (INSTRT) begin in_cnt = 1; inst_seen++; end
        else if (in_cnt != 0) in_cnt++;
        if (in_cnt == 4) begin
          INDONE = 1'b1;
          in_cnt = 0;
          if (inst_seen == stop_iter) STOP = 1'b1;
        end
`ifdef BLIT_STEP_EN
        if (PAUSED && (auto_step != 0 || step_tok != step_done)) begin
          STEP = 1'b1;
          step_done = step_tok;
        end
`endif
      end
      rdpar_q = RDPAR;
    end
  end

  task automatic go(input logic [7:0] ld, input logic prd);
    @(negedge CCLK);
    OUTLD = ld; PARRDEN = prd; START = 1'b1;
    @(negedge CCLK);
    START = 1'b0; OUTLD = 8'($urandom); PARRDEN = ~prd;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    do begin @(negedge CCLK); n++; end while (BUSY && n < lim);
    chk(name, int'(BUSY), 0);
  endtask

  task automatic wait_instrt(input int lim);
    int n = 0;
    do begin @(negedge CCLK); n++; end while (!INSTRT && n < lim);
    chk("instrt_seen", int'(INSTRT), 1);
  endtask

  task automatic drain(input string name);
    @(negedge CCLK);
    chk(name, q.size(), 0);
  endtask

  initial begin
    SRESET = 1'b1; START = 1'b0; OUTLD = '0; PARRDEN = 1'b0;
    repeat (3) @(negedge CCLK);
    SRESET = 1'b0;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_rdpar", int'(RDPAR), 0);
    chk("rst_instrt", int'(INSTRT), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_stopped", int'(STOPPED), 0);
    chk("rst_outcnt", int'(OUTCNT), 0);

    // 3 iterations, parameters re-read every time
    expect_ev("R", 8'd3); expect_ev("I", 8'd3);
    expect_ev("R", 8'd2); expect_ev("I", 8'd2);
    expect_ev("R", 8'd1); expect_ev("I", 8'd1);
    expect_ev("D", 8'd0);
    go(8'd3, 1'b1);
    chk("t1_busy", int'(BUSY), 1);
    wait_idle("t1_idle", 200);
    chk("t1_outcnt", int'(OUTCNT), 0);
    drain("t1_queue");

    // 4 iterations, parameters read once
    expect_ev("R", 8'd4);
    for (int unsigned k = 0; k < 4; k++) expect_ev("I", 8'(4 - k));
    expect_ev("D", 8'd0);
    go(8'd4, 1'b0);
    wait_idle("t2_idle", 200);
    drain("t2_queue");

    // load 0 means 256 iterations; OUTCNT wraps to 255 at the first NEXT
    expect_ev("R", 8'd0);
    for (int unsigned k = 0; k < 256; k++) expect_ev("I", 8'(256 - k));
    expect_ev("D", 8'd0);
    go(8'd0, 1'b0);
    wait_idle("t3_idle", 4000);
    drain("t3_queue");

    // STOP coincident with INDONE on iteration 2 of 5
    stop_iter = 2;
    expect_ev("R", 8'd5); expect_ev("I", 8'd5);
    expect_ev("R", 8'd4); expect_ev("I", 8'd4);
    go(8'd5, 1'b1);
    wait_idle("t4_idle", 200);
    chk("t4_stopped", int'(STOPPED), 1);
    chk("t4_outcnt", int'(OUTCNT), 4);
    chk("t4_done", int'(DONE), 0);
    stop_iter = 0;
    drain("t4_queue");
    expect_ev("R", 8'd1); expect_ev("I", 8'd1); expect_ev("D", 8'd0);
    go(8'd1, 1'b1);
    chk("t4_stopped_clr", int'(STOPPED), 0);
    wait_idle("t4b_idle", 200);
    chk("t4b_stopped", int'(STOPPED), 0);
    drain("t4b_queue");

    // START while busy is ignored
    expect_ev("R", 8'd2); expect_ev("I", 8'd2); expect_ev("I", 8'd1); expect_ev("D", 8'd0);
    go(8'd2, 1'b0);
    wait_instrt(50);
    OUTLD = 8'd7; PARRDEN = 1'b1; START = 1'b1;
    @(negedge CCLK);
    START = 1'b0;
    chk("t5_outcnt_kept", int'(OUTCNT), 2);
    wait_idle("t5_idle", 200);
    drain("t5_queue");

    // SRESET during INNER
    expect_ev("R", 8'd5); expect_ev("I", 8'd5);
    go(8'd5, 1'b1);
    wait_instrt(50);
    @(negedge CCLK);
    SRESET = 1'b1;
    @(negedge CCLK);
    SRESET = 1'b0;
    chk("t6_busy", int'(BUSY), 0);
    chk("t6_outcnt", int'(OUTCNT), 0);
    chk("t6_stopped", int'(STOPPED), 0);
    chk("t6_rdpar", int'(RDPAR), 0);
    drain("t6_queue");

`ifdef BLIT_STEP_EN
    // single-step: stays in HOLD until STEP
    begin
      int n;
      auto_step = 0;
      expect_ev("R", 8'd2); expect_ev("I", 8'd2);
      expect_ev("R", 8'd1); expect_ev("I", 8'd1); expect_ev("D", 8'd0);
      go(8'd2, 1'b1);
      n = 0;
      do begin @(negedge CCLK); n++; end while (!PAUSED && n < 100);
      chk("t7_paused", int'(PAUSED), 1);
      for (int unsigned k = 0; k < 10; k++) begin
        @(negedge CCLK);
        chk("t7_hold_paused", int'(PAUSED), 1);
        chk("t7_hold_instrt", int'(INSTRT), 0);
        chk("t7_hold_busy", int'(BUSY), 1);
      end
      step_tok++;
      wait_idle("t7_idle", 200);
      drain("t7_queue");
      auto_step = 1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
